// File: rtl/i2c_poll_sequencer.sv
// Periodic I2C register poller feeding an AXI IIC front-end: one core init, then timed sweeps of a register table.
// Optional `define I2C_SEQ_CHANGE_DETECT_EN adds o_changed and gates o_sweep_done on a detected change.
module i2c_poll_sequencer #(
    parameter int unsigned NUM_REGS           = 4,
    parameter int unsigned POLL_PERIOD_CYCLES = 100000,
    parameter int unsigned TIMEOUT_CYCLES     = 1000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_enable,
    input  logic [6:0]               i_device_addr,
    input  logic [16*NUM_REGS-1:0]   i_reg_addr,
    input  logic [3*NUM_REGS-1:0]    i_read_len,
    output logic [6:0]               o_device_addr,
    output logic [15:0]              o_I2C_REG_ADDR,
    output logic                     o_I2C_INIT_wstrobe,
    output logic [7:0]               o_I2C_READ_LEN,
    output logic                     o_I2C_READ_LEN_wstrobe,
    input  logic                     i_I2C_IDLE,
    input  logic [31:0]              i_I2C_RX_DATA,
    output logic [32*NUM_REGS-1:0]   o_result,
    output logic [NUM_REGS-1:0]      o_result_valid,
`ifdef I2C_SEQ_CHANGE_DETECT_EN
    output logic [NUM_REGS-1:0]      o_changed,
`endif
    output logic                     o_sweep_done,
    output logic                     o_timeout
);

    typedef enum logic [2:0] {
        S_OFF,
        S_INIT,
        S_INIT_WAIT,
        S_ISSUE,
        S_WAIT,
        S_NEXT,
        S_PERIOD
    } state_t;

    state_t      state, state_next;
    logic [2:0]  idx;
    logic        init_done;
    logic [31:0] period_cnt;
    logic [31:0] to_cnt;

    logic [15:0] addr_tab [8];
    logic [2:0]  len_tab  [8];
    logic [2:0]  cur_len;
    logic        len_ok;
    logic        last;

    logic init_fire, read_fire, sweep_start, capture, skip, wait_tick, advance, end_sweep;

    // Table padded to 8 entries so the 3-bit index always addresses a real element.
    for (genvar g = 0; g < 8; g++) begin : g_tab
        if (g < NUM_REGS) begin : g_used
            assign addr_tab[g] = i_reg_addr[16*g +: 16];
            assign len_tab[g]  = i_read_len[3*g +: 3];
        end else begin : g_unused
            assign addr_tab[g] = '0;
            assign len_tab[g]  = '0;
        end
    end

    assign cur_len = len_tab[idx];
    assign len_ok  = (cur_len != 3'd0) && (cur_len <= 3'd4);
    assign last    = (idx == 3'(NUM_REGS - 1));

    always_comb begin
        state_next  = state;
        init_fire   = 1'b0;
        read_fire   = 1'b0;
        sweep_start = 1'b0;
        capture     = 1'b0;
        skip        = 1'b0;
        wait_tick   = 1'b0;
        advance     = 1'b0;
        end_sweep   = 1'b0;
        case (state)
            S_OFF: begin
                if (i_enable) state_next = init_done ? S_PERIOD : S_INIT;
            end
            S_INIT: begin
                if (i_I2C_IDLE) begin
                    init_fire  = 1'b1;
                    state_next = S_INIT_WAIT;
                end
            end
            // Strobe is registered, so the wait proper starts once the strobe cycle is over.
            S_INIT_WAIT: begin
                if (!o_I2C_INIT_wstrobe) begin
                    if (i_I2C_IDLE) begin
                        sweep_start = 1'b1;
                        state_next  = S_ISSUE;
                    end else begin
                        wait_tick = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (len_ok) begin
                    read_fire  = 1'b1;
                    state_next = S_WAIT;
                end else begin
                    skip       = 1'b1;
                    state_next = S_NEXT;
                end
            end
            S_WAIT: begin
                if (!o_I2C_READ_LEN_wstrobe) begin
                    if (i_I2C_IDLE) begin
                        capture    = 1'b1;
                        state_next = S_NEXT;
                    end else begin
                        wait_tick = 1'b1;
                    end
                end
            end
            S_NEXT: begin
                if (last) begin
                    end_sweep  = 1'b1;
                    state_next = i_enable ? S_PERIOD : S_OFF;
                end else if (!i_enable) begin
                    state_next = S_OFF;
                end else begin
                    advance    = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_PERIOD: begin
                if (!i_enable) begin
                    state_next = S_OFF;
                end else if (period_cnt >= 32'(POLL_PERIOD_CYCLES)) begin
                    sweep_start = 1'b1;
                    state_next  = S_ISSUE;
                end
            end
            default: state_next = S_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                  <= S_OFF;
            idx                    <= '0;
            init_done              <= 1'b0;
            period_cnt             <= '0;
            to_cnt                 <= '0;
            o_device_addr          <= '0;
            o_I2C_REG_ADDR         <= '0;
            o_I2C_INIT_wstrobe     <= 1'b0;
            o_I2C_READ_LEN         <= '0;
            o_I2C_READ_LEN_wstrobe <= 1'b0;
            o_result               <= '0;
            o_result_valid         <= '0;
            o_sweep_done           <= 1'b0;
            o_timeout              <= 1'b0;
`ifdef I2C_SEQ_CHANGE_DETECT_EN
            o_changed              <= '0;
`endif
        end else begin
            state                  <= state_next;
            o_I2C_INIT_wstrobe     <= init_fire;
            o_I2C_READ_LEN_wstrobe <= read_fire;
            o_sweep_done           <= 1'b0;

            if (period_cnt < 32'(POLL_PERIOD_CYCLES)) period_cnt <= period_cnt + 32'd1;

            // Count starts at 1 so the next sweep's S_ISSUE lands exactly POLL_PERIOD_CYCLES later.
            if (sweep_start) begin
                o_device_addr <= i_device_addr;
                idx           <= '0;
                period_cnt    <= 32'd1;
                init_done     <= 1'b1;
`ifdef I2C_SEQ_CHANGE_DETECT_EN
                o_changed     <= '0;
`endif
            end

            if (init_fire) to_cnt <= '0;

            if (read_fire) begin
                o_I2C_REG_ADDR <= addr_tab[idx];
                o_I2C_READ_LEN <= {5'b0, cur_len};
                to_cnt         <= '0;
            end

            if (wait_tick && (to_cnt < 32'(TIMEOUT_CYCLES))) begin
                to_cnt <= to_cnt + 32'd1;
                if (to_cnt == 32'(TIMEOUT_CYCLES - 1)) o_timeout <= 1'b1;
            end

            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (idx == 3'(i)) begin
                    if (skip) o_result_valid[i] <= 1'b0;
                    if (wait_tick && (state == S_WAIT) && (to_cnt == 32'(TIMEOUT_CYCLES - 1)))
                        o_result_valid[i] <= 1'b0;
                    if (capture) begin
                        o_result[32*i +: 32] <= i_I2C_RX_DATA;
                        o_result_valid[i]    <= 1'b1;
`ifdef I2C_SEQ_CHANGE_DETECT_EN
                        if ((o_result[32*i +: 32] != i_I2C_RX_DATA) || !o_result_valid[i])
                            o_changed[i] <= 1'b1;
`endif
                    end
                end
            end

            if (advance) idx <= idx + 3'd1;

            if (end_sweep) begin
`ifdef I2C_SEQ_CHANGE_DETECT_EN
                o_sweep_done <= |o_changed;
`else
                o_sweep_done <= 1'b1;
`endif
            end
        end
    end

endmodule
